// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : psum_accumulator
// Brief    : Sums a PE row's products, accumulates over a window, requantizes
//            to int8 and queues results in a credit-protected output FIFO.
// Revision : 1.0
// ============================================================================
module psum_accumulator #(
    parameter int NUM_PE    = 9,
    parameter int ACC_W     = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prod_valid,
    input  logic                     prod_first,
    input  logic                     prod_last,
    input  logic [NUM_PE*16-1:0]     products,
    output logic                     in_ready,
    input  logic [ACC_W-1:0]         bias,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     ovf
);

    localparam int c_PTR_W = $clog2(OUT_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic signed [ACC_W:0] c_Q_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] c_Q_MIN = -(ACC_W+1)'(128);

    logic                        w_accept;
    logic signed [ACC_W-1:0]     w_row_sum;

    logic                        r_s1_valid;
    logic                        r_s1_first;
    logic                        r_s1_last;
    logic signed [ACC_W-1:0]     r_s1_sum;
    logic signed [ACC_W-1:0]     r_s1_bias;
    logic [4:0]                  r_s1_shift;
    logic                        r_s1_relu;

    logic signed [ACC_W-1:0]     r_acc;
    logic                        r_s2_last;
    logic [4:0]                  r_s2_shift;
    logic                        r_s2_relu;
    logic                        r_ovf;

    logic signed [ACC_W-1:0]     w_acc_base;
    logic signed [ACC_W-1:0]     w_acc_next;
    logic                        w_add_ovf;

    logic signed [ACC_W:0]       w_acc_ext;
    logic signed [ACC_W:0]       w_round;
    logic signed [ACC_W:0]       w_rounded;
    logic signed [ACC_W:0]       w_shifted;
    logic signed [ACC_W:0]       w_clamped;
    logic [7:0]                  w_q8;

    logic [7:0]                  r_mem [OUT_DEPTH];
    logic [c_PTR_W-1:0]          r_wr_ptr;
    logic [c_PTR_W-1:0]          r_rd_ptr;
    logic [c_CNT_W-1:0]          r_count;
    logic [1:0]                  r_pending;
    logic [c_CNT_W:0]            w_credit_used;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_last_accept;

    // Credits count both queued results and results still in the pipe.
    assign w_credit_used = {1'b0, r_count} + (c_CNT_W+1)'(r_pending);
    assign in_ready      = (w_credit_used < (c_CNT_W+1)'(OUT_DEPTH));
    assign w_accept      = prod_valid & in_ready;
    assign w_last_accept = w_accept & prod_last;

    // ---------------- S1: row reduction ----------------
    always_comb begin
        w_row_sum = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_row_sum = w_row_sum
                      + {{(ACC_W-16){products[16*i+15]}}, products[16*i +: 16]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_bias  <= '0;
            r_s1_shift <= '0;
            r_s1_relu  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_first <= prod_first;
                r_s1_last  <= prod_last;
                r_s1_sum   <= w_row_sum;
                r_s1_bias  <= bias;
                r_s1_shift <= shift;
                r_s1_relu  <= relu_en;
            end
        end
    end

    // ---------------- S2: accumulator ----------------
    assign w_acc_base = r_s1_first ? r_s1_bias : r_acc;
    assign w_acc_next = w_acc_base + r_s1_sum;
    assign w_add_ovf  = (w_acc_base[ACC_W-1] == r_s1_sum[ACC_W-1])
                      && (w_acc_next[ACC_W-1] != w_acc_base[ACC_W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_s2_last  <= 1'b0;
            r_s2_shift <= '0;
            r_s2_relu  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_s2_last <= r_s1_valid & r_s1_last;
            if (r_s1_valid) begin
                r_acc      <= w_acc_next;
                r_s2_shift <= r_s1_shift;
                r_s2_relu  <= r_s1_relu;
                if (w_add_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign ovf = r_ovf;

    // ---------------- S3: requantization ----------------
    // One extra bit keeps acc + rounding constant from wrapping.
    assign w_acc_ext = {r_acc[ACC_W-1], r_acc};

    always_comb begin
        w_round = '0;
        if (r_s2_shift != 5'd0) begin
            w_round = (ACC_W+1)'(1) << (r_s2_shift - 5'd1);
        end
    end

    assign w_rounded = w_acc_ext + w_round;
    assign w_shifted = w_rounded >>> r_s2_shift;

    always_comb begin
        w_clamped = w_shifted;
        if (r_s2_relu && w_shifted < 0) begin
            w_clamped = '0;
        end
    end

    always_comb begin
        if (w_clamped > c_Q_MAX) begin
            w_q8 = 8'sd127;
        end else if (w_clamped < c_Q_MIN) begin
            w_q8 = 8'h80;
        end else begin
            w_q8 = w_clamped[7:0];
        end
    end

    // ---------------- Output FIFO ----------------
    assign w_push = r_s2_last;
    assign w_pop  = (r_count != '0) & out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_q8;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            case ({w_last_accept, w_push})
                2'b10:   r_pending <= r_pending + 2'd1;
                2'b01:   r_pending <= r_pending - 2'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_accumulator
// Brief    : Directed self-checking bench with a result scoreboard.
// Revision : 1.0
// ============================================================================
module tb_psum_accumulator;

    localparam int NUM_PE    = 9;
    localparam int ACC_W     = 32;
    localparam int OUT_DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    prod_valid;
    logic                    prod_first;
    logic                    prod_last;
    logic [NUM_PE*16-1:0]    products;
    logic                    in_ready;
    logic [ACC_W-1:0]        bias;
    logic [4:0]              shift;
    logic                    relu_en;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_data;
    logic                    ovf;

    int      checks = 0;
    int      errors = 0;
    longint  exp_q[$];
    longint  m_acc;
    logic    m_ovf;

    always #5 clk = ~clk;

    psum_accumulator #(
        .NUM_PE    (NUM_PE),
        .ACC_W     (ACC_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prod_valid (prod_valid),
        .prod_first (prod_first),
        .prod_last  (prod_last),
        .products   (products),
        .in_ready   (in_ready),
        .bias       (bias),
        .shift      (shift),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .ovf        (ovf)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [NUM_PE*16-1:0] all_pe(input logic [15:0] v);
        logic [NUM_PE*16-1:0] p;
        for (int i = 0; i < NUM_PE; i++) p[16*i +: 16] = v;
        return p;
    endfunction

    function automatic logic [NUM_PE*16-1:0] pe0_only(input logic [15:0] v);
        logic [NUM_PE*16-1:0] p;
        p = '0;
        p[15:0] = v;
        return p;
    endfunction

    function automatic longint wrap32(input longint v);
        logic [63:0] t;
        t = v;
        return longint'($signed(t[31:0]));
    endfunction

    function automatic longint requant(input longint acc, input int sh, input bit relu);
        longint r;
        if (sh == 0) r = acc;
        else         r = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // Drive one beat, wait (bounded) for in_ready, then update the model.
    task automatic send_beat(input logic [NUM_PE*16-1:0] p, input bit first,
                             input bit last, input longint b, input int sh,
                             input bit relu);
        int     waited;
        longint sum;
        longint nxt;
        waited     = 0;
        prod_valid = 1'b1;
        products   = p;
        prod_first = first;
        prod_last  = last;
        bias       = b[ACC_W-1:0];
        shift      = sh[4:0];
        relu_en    = relu;
        while (in_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", in_ready, 1);
            prod_valid = 1'b0;
            return;
        end
        tick();
        prod_valid = 1'b0;
        sum = 0;
        for (int i = 0; i < NUM_PE; i++) sum += longint'($signed(p[16*i +: 16]));
        nxt = (first ? b : m_acc) + sum;
        if (nxt > 64'sd2147483647 || nxt < -64'sd2147483648) m_ovf = 1'b1;
        m_acc = wrap32(nxt);
        if (last) exp_q.push_back(requant(m_acc, sh, relu));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid !== 1'b0) && n < 100) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        exp_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        check("rst_out_valid", out_valid, 0);
        rst = 1'b0;
    endtask

    // Scoreboard consumer: a pop happens on the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow: observed out_data %0d with empty scoreboard, expected no output",
                       $signed(out_data));
            end
            if (exp_q.size() > 0) check("out_data", $signed(out_data), exp_q.pop_front());
        end
    end

    initial begin
        rst        = 1'b1;
        prod_valid = 1'b0;
        prod_first = 1'b0;
        prod_last  = 1'b0;
        products   = '0;
        bias       = '0;
        shift      = '0;
        relu_en    = 1'b0;
        out_ready  = 1'b1;
        m_acc      = 0;
        m_ovf      = 1'b0;
        tick(2);
        rst = 1'b0;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_ovf", ovf, 0);
        check("reset_in_ready", in_ready, 1);

        // Single-beat window and latency
        send_beat(all_pe(16'd1), 1, 1, 0, 0, 0);
        check("lat_t1", out_valid, 0);
        tick();
        check("lat_t2", out_valid, 0);
        tick();
        check("lat_t3", out_valid, 1);
        check("lat_data", $signed(out_data), 9);
        wait_drain();
        check("ovf_clean", ovf, m_ovf);

        // Inputs are ignored without prod_valid
        prod_first = 1'b1;
        prod_last  = 1'b1;
        products   = all_pe(16'd77);
        tick(6);

        // Three-beat windows, back to back
        send_beat(all_pe(16'd100), 1, 0, 300, 0, 0);
        send_beat(all_pe(16'd100), 0, 0, 0, 0, 0);
        send_beat(all_pe(16'd100), 0, 1, 0, 5, 0);
        send_beat(all_pe(16'd100), 1, 0, 300, 0, 0);
        send_beat(all_pe(16'd100), 0, 0, 0, 0, 0);
        send_beat(all_pe(16'd100), 0, 1, 0, 4, 0);
        wait_drain();

        // Negative values and ReLU
        send_beat(all_pe(-16'sd50), 1, 1, 0, 1, 0);
        send_beat(all_pe(-16'sd50), 1, 1, 0, 1, 1);
        send_beat(all_pe(-16'sd1), 1, 1, 0, 0, 0);
        wait_drain();

        // Backpressure: four credits then stall
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_beat(pe0_only(16'(k)), 1, 1, 0, 0, 0);
        check("bp_in_ready_low", in_ready, 0);
        prod_valid = 1'b1;
        products   = pe0_only(16'd5);
        prod_first = 1'b1;
        prod_last  = 1'b1;
        tick(8);
        check("bp_stall_in_ready", in_ready, 0);
        check("bp_full_valid", out_valid, 1);
        check("bp_head", $signed(out_data), 1);
        out_ready = 1'b1;
        send_beat(pe0_only(16'd5), 1, 1, 0, 0, 0);
        send_beat(pe0_only(16'd6), 1, 1, 0, 0, 0);
        wait_drain();

        // Reset in the middle of a window
        send_beat(all_pe(16'd100), 1, 0, 300, 0, 0);
        do_reset();
        check("mid_rst_in_ready", in_ready, 1);
        send_beat(all_pe(16'd1), 0, 1, 0, 0, 0);
        wait_drain();

        // Overflow is sticky until reset
        send_beat(all_pe(16'd1), 1, 1, 2147483647, 0, 0);
        wait_drain();
        check("ovf_set", ovf, m_ovf);
        send_beat(all_pe(16'd1), 1, 1, 0, 0, 0);
        wait_drain();
        check("ovf_sticky", ovf, 1);
        do_reset();
        check("ovf_cleared", ovf, 0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream consumer of a row of NUM_PE basic multiplier PEs.
- Each cycle it sums the row's registered signed 16-bit products and accumulates the sums over a multi-beat window (input channels / kernel taps), with the bias preloaded on the first beat.
- On the last beat it requantizes the accumulator to int8 (rounding shift, optional ReLU, saturation) and queues the result in an output FIFO with a valid/ready handshake.
- It throttles the PE array via in_ready.

Parameters:
NUM_PE, 9, number of 16-bit products summed per beat
ACC_W, 32, accumulator width (signed)
OUT_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset; synchronous, active-high
prod_valid  input  1  products valid this cycle
prod_first  input  1  first beat of window (load bias)
prod_last  input  1  last beat of window (emit result)
products  input  NUM_PE*16  packed signed products; PE i at bits [16i+15:16i]
in_ready  output  1  beat accepted when prod_valid & in_ready
bias  input  ACC_W  signed bias, sampled with a first beat
shift  input  5  requant right-shift, sampled with a last beat
relu_en  input  1  clamp negatives to 0, sampled with a last beat
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer ready
out_data  output  8  signed int8 result at FIFO head
ovf  output  1  sticky accumulator-overflow flag

Behaviour:
- Reset, synchronous and active-high:
  - Clears S1/S2 valid bits, accumulator, FIFO pointers/count, pending counter and ovf.
  - Outputs after reset: out_valid=0, out_data=0, ovf=0, in_ready=1.
  - In-flight beats are dropped.
  - Reset asserted mid-window: the next beat without prod_first accumulates onto 0.
- S1, edge after acceptance:
  - s1_sum = signed sum of the NUM_PE products, each sign-extended to ACC_W.
  - first, last, bias, shift and relu_en are registered alongside s1_sum.
  - No wrap is possible in S1 at default widths.
- S2, the accumulator, on s1_valid:
  - acc <= (s1_first ? s1_bias : acc) + s1_sum, modulo 2^ACC_W.
  - Signed overflow of this add sets ovf; ovf stays 1 until rst.
  - first and last on the same beat form a single-beat window.
  - A repeated first mid-window restarts the window; this is not an error.
- S3, requant, combinational from acc when s2_last; written into the FIFO on the next edge:
  - r = shift==0 ? acc : (acc + 2^(shift-1)) >>> shift, computed at ACC_W+1 bits, round-half-up.
  - If relu_en and r<0, then r=0.
  - Saturate to [-128,127].
- Latency:
  - Last beat accepted in cycle T; FIFO written at the end of T+2; out_valid=1 in T+3 if the FIFO was empty.
  - Accumulate throughput is 1 beat/cycle.
- Output FIFO:
  - OUT_DEPTH entries, in order; out_data is the head entry, 0 when empty.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full; count is unchanged.
- Credit logic:
  - pending = number of accepted last beats not yet written to the FIFO (0..2).
  - in_ready = (fifo_count + pending + (accepting_last_this_cycle? n/a)) < OUT_DEPTH, computed from registered state only: in_ready = (fifo_count + pending) < OUT_DEPTH.
  - Non-last beats are also blocked while in_ready=0. This guarantees no FIFO overflow and no lost result.
  - prod_valid while in_ready=0: the beat is not consumed; the producer holds it (pipe stall upstream).
- Ignored inputs:
  - prod_first/prod_last/bias/shift/relu_en are ignored when prod_valid=0.
  - shift>ACC_W-1 yields 0 or -1, then saturation/ReLU apply.

Test Plan:
1. Single-beat window: all 9 products=1, first=last=1, bias=0, shift=0, relu off -> out_data=9, out_valid rises exactly 3 cycles after the accept cycle; ovf=0.
2. Three-beat window, back-to-back: products all 100 (sum 900/beat), bias=300 on the first beat, shift=5 on the last -> acc=3000, (3000+16)>>>5 = 94 -> out_data=94; same with shift=4 -> 188 saturates to 127.
3. Negative and ReLU: products all -50 (sum -450), single beat, relu off, shift=1 -> (-450+1)>>>1 = -225 -> -128; relu on -> 0; shift=0, products -1 each, relu off -> -9.
4. Backpressure: out_ready=0, drive 6 consecutive single-beat windows with distinct values 1..6 -> exactly 4 accepted; in_ready=0 from the cycle fifo_count+pending reaches 4. Raise out_ready -> outputs 1,2,3,4 then 5,6 after re-acceptance, in order, with no duplicates or loss. Simultaneous push/pop at full leaves count unchanged.
5. Reset mid-window: first beat sum 900 with bias 300, assert rst one cycle, then a non-first last beat sum 9 -> out_data=9 (no stale acc/bias). FIFO was emptied by reset and out_valid=0 during reset.
6. Overflow: bias=2147483647, single beat sum 9 -> acc wraps to -2147483640 -> out_data=-128 (shift 0), ovf=1. ovf stays 1 through further clean windows until rst.
